// File: rtl/regfile_mp.sv
// regfile_mp: parametrised integer register file.
// - NUM_RD combinational read ports and two byte-enabled write ports.
//   Write port 1 has priority over port 0 on overlapping bytes.
// - After reset, a clear sequencer zeroes the array and then raises ready.
// - A registered commit trace records each write port's activity.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes to
// the read ports.
module regfile_mp #(
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic [DW/8-1:0]      we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [DW-1:0]        wdata0,
    input  logic [31:0]          pc0,
    input  logic [DW/8-1:0]      we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [DW-1:0]        wdata1,
    input  logic [31:0]          pc1,
    input  logic [NUM_RD-1:0]    re,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD*DW-1:0] rdata,
    output logic [1:0]           trace_we,
    output logic [2*AW-1:0]      trace_addr,
    output logic [2*DW-1:0]      trace_data,
    output logic [2*32-1:0]      trace_pc
);
    localparam int NB = DW / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    typedef struct packed {
        logic [NB-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   pc;
    } wr_req_t;

    state_t                     state, state_nxt;
    logic [AW-1:0]              idx;
    logic [DW-1:0]              regs [DEPTH];
    wr_req_t [1:0]              wr;
    logic [1:0]                 act;
    logic [1:0][DW-1:0]         merged;
    logic [NUM_RD-1:0][AW-1:0]  ra;
    logic [NUM_RD-1:0][DW-1:0]  rd;

    assign wr[0] = '{we: we0, addr: waddr0, data: wdata0, pc: pc0};
    assign wr[1] = '{we: we1, addr: waddr1, data: wdata1, pc: pc1};
    assign ra    = raddr;
    assign rdata = rd;

    // A port is active only in RUN, with some byte enabled, and not targeting r0.
    for (genvar p = 0; p < 2; p++) begin : g_act
        assign act[p] = (state == RUN) && (|wr[p].we) && (wr[p].addr != '0);
    end

    // Per-port post-write word. Port 1 bytes win; this also merges same-address writes.
    always_comb begin
        merged = '0;
        for (int p = 0; p < 2; p++) begin
            merged[p] = regs[wr[p].addr];
            for (int b = 0; b < NB; b++) begin
                if (act[1] && wr[1].addr == wr[p].addr && wr[1].we[b])
                    merged[p][b*8 +: 8] = wr[1].data[b*8 +: 8];
                else if (act[0] && wr[0].addr == wr[p].addr && wr[0].we[b])
                    merged[p][b*8 +: 8] = wr[0].data[b*8 +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nxt;
    end

    // Next state: leave CLEAR once the last index has been zeroed.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && idx == AW'(DEPTH - 1)) state_nxt = RUN;
    end

    // Clear index, ready flag and commit trace.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= AW'(1);
            ready      <= 1'b0;
            trace_we   <= '0;
            trace_addr <= '0;
            trace_data <= '0;
            trace_pc   <= '0;
        end else if (state == CLEAR) begin
            idx      <= idx + AW'(1);
            ready    <= (idx == AW'(DEPTH - 1));
            trace_we <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                trace_we[p] <= act[p];
                if (act[p]) begin
                    trace_addr[p*AW +: AW] <= wr[p].addr;
                    trace_data[p*DW +: DW] <= merged[p];
                    trace_pc[p*32 +: 32]   <= wr[p].pc;
                end
            end
        end
    end

    // Array update. The reset edge itself leaves the contents alone.
    // Both ports hitting the same address write the identical merged word.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                regs[idx] <= '0;
            end else begin
                for (int p = 0; p < 2; p++)
                    if (act[p]) regs[wr[p].addr] <= merged[p];
            end
        end
    end

    // One read lane per port.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic          en, hit;
        logic [DW-1:0] hit_word;

        assign en = rst && ready && re[k] && (ra[k] != '0);
`ifdef REGFILE_BYPASS_EN
        assign hit      = (act[1] && wr[1].addr == ra[k]) || (act[0] && wr[0].addr == ra[k]);
        assign hit_word = (act[1] && wr[1].addr == ra[k]) ? merged[1] : merged[0];
`else
        assign hit      = 1'b0;
        assign hit_word = '0;
`endif
        regfile_mp_rd #(.DW(DW)) u_rd (
            .en       (en),
            .hit      (hit),
            .hit_word (hit_word),
            .rword    (regs[ra[k]]),
            .rdata    (rd[k])
        );
    end
endmodule

// Read lane: gating plus an optional forwarding mux.
module regfile_mp_rd #(
    parameter int DW = 32
) (
    input  logic          en,
    input  logic          hit,
    input  logic [DW-1:0] hit_word,
    input  logic [DW-1:0] rword,
    output logic [DW-1:0] rdata
);
    assign rdata = !en ? '0 : (hit ? hit_word : rword);
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomised and directed checks of regfile_mp.
// The bench checks against a byte-level array model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [3:0]  we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1, pc0, pc1;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  trace_we;
    logic [9:0]  trace_addr;
    logic [63:0] trace_data;
    logic [63:0] trace_pc;

    int vecs = 0;
    int errs = 0;

    logic [31:0] mregs [32];
    logic [1:0]  etw;
    logic [4:0]  eta [2];
    logic [31:0] etd [2];
    logic [31:0] etp [2];

    regfile_mp dut (
        .clk(clk), .rst(rst), .ready(ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .pc0(pc0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .pc1(pc1),
        .re(re), .raddr(raddr), .rdata(rdata),
        .trace_we(trace_we), .trace_addr(trace_addr),
        .trace_data(trace_data), .trace_pc(trace_pc)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = '0; waddr0 = '0; wdata0 = '0; pc0 = '0;
        we1 = '0; waddr1 = '0; wdata1 = '0; pc1 = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        etw = '0;
        for (int p = 0; p < 2; p++) begin
            eta[p] = '0; etd[p] = '0; etp[p] = '0;
        end
    endtask

    // Word port p would leave behind: apply port 0 bytes, then port 1 bytes.
    function automatic logic [31:0] mword(input int p);
        logic [4:0]  a;
        logic [31:0] w;
        a = (p == 1) ? waddr1 : waddr0;
        w = mregs[a];
        if (waddr0 == a) for (int b = 0; b < 4; b++) if (we0[b]) w[b*8 +: 8] = wdata0[b*8 +: 8];
        if (waddr1 == a) for (int b = 0; b < 4; b++) if (we1[b]) w[b*8 +: 8] = wdata1[b*8 +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_read(input int k);
        logic [4:0] a;
        a = raddr[k*5 +: 5];
        if (!re[k] || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we1 != 0 && waddr1 == a) return mword(1);
        if (we0 != 0 && waddr0 == a) return mword(0);
`endif
        return mregs[a];
    endfunction

    // Apply the current write inputs to the model, as the next RUN edge would.
    task automatic model_step();
        logic        a0, a1;
        logic [31:0] w0, w1;
        a0 = (we0 != 0) && (waddr0 != 0);
        a1 = (we1 != 0) && (waddr1 != 0);
        w0 = mword(0);
        w1 = mword(1);
        etw = {a1, a0};
        if (a0) begin eta[0] = waddr0; etd[0] = w0; etp[0] = pc0; end
        if (a1) begin eta[1] = waddr1; etd[1] = w1; etp[1] = pc1; end
        if (a0) mregs[waddr0] = w0;
        if (a1) mregs[waddr1] = w1;
    endtask

    task automatic test_reset();
        int n;
        logic tw_bad;
        rst = 1'b0; idle(); re = 2'b11; raddr = {5'd5, 5'd1};
        cyc();
        model_reset();
        vecs++;
        if ({ready, trace_we, rdata} !== {1'b0, 2'b00, 64'h0}) begin
            errs++;
            $display("FAIL reset_state: ready=%b trace_we=%b rdata=%h, expected 0/00/0", ready, trace_we, rdata);
        end
        // Writes to r1 during the whole clear must be ignored.
        rst = 1'b1;
        we0 = 4'hF; waddr0 = 5'd1; wdata0 = 32'hFFFF_FFFF;
        n = 0; tw_bad = 1'b0;
        while (!ready && n < 100) begin
            cyc();
            n++;
            if (trace_we !== 2'b00) tw_bad = 1'b1;
        end
        vecs++;
        if (n !== 31) begin
            errs++;
            $display("FAIL clear_len: ready after %0d cycles, expected 31", n);
        end
        vecs++;
        if (tw_bad) begin
            errs++;
            $display("FAIL clear_trace: trace_we nonzero during clear, expected 00");
        end
        idle();
        #1;
        vecs++;
        if (rdata !== 64'h0) begin
            errs++;
            $display("FAIL clear_ignore: rdata=%h, expected 0", rdata);
        end
    endtask

    task automatic test_basic_write();
        we0 = 4'hF; waddr0 = 5'd3; wdata0 = 32'h1234_5678; pc0 = 32'hBFC0_0010;
        model_step();
        cyc();
        vecs++;
        if ({trace_we, trace_addr[4:0], trace_data[31:0], trace_pc[31:0]} !==
            {2'b01, 5'd3, 32'h1234_5678, 32'hBFC0_0010}) begin
            errs++;
            $display("FAIL basic_trace: we=%b addr=%0d data=%h pc=%h, expected 01/3/12345678/bfc00010",
                     trace_we, trace_addr[4:0], trace_data[31:0], trace_pc[31:0]);
        end
        idle(); re = 2'b01; raddr = {5'd0, 5'd3};
        #1;
        vecs++;
        if (rdata[31:0] !== 32'h1234_5678) begin
            errs++;
            $display("FAIL basic_read: rdata0=%h, expected 12345678", rdata[31:0]);
        end
    endtask

    task automatic test_merge();
        we0 = 4'hF; waddr0 = 5'd4; wdata0 = 32'hAABB_CCDD; pc0 = 32'h100;
        model_step();
        cyc();
        we0 = 4'b0011; waddr0 = 5'd4; wdata0 = 32'h1111_1111; pc0 = 32'h200;
        we1 = 4'b0110; waddr1 = 5'd4; wdata1 = 32'h2222_2222; pc1 = 32'h204;
        model_step();
        cyc();
        vecs++;
        if ({trace_we, trace_data, trace_pc} !== {2'b11, 32'hAA22_2211, 32'hAA22_2211, 32'h204, 32'h200}) begin
            errs++;
            $display("FAIL merge_trace: we=%b data=%h pc=%h, expected 11/aa222211 x2/204,200",
                     trace_we, trace_data, trace_pc);
        end
        idle(); re = 2'b10; raddr = {5'd4, 5'd0};
        #1;
        vecs++;
        if (rdata[63:32] !== 32'hAA22_2211) begin
            errs++;
            $display("FAIL merge_read: rdata1=%h, expected aa222211", rdata[63:32]);
        end
    endtask

    task automatic test_addr0();
        we1 = 4'hF; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF; pc1 = 32'h300;
        model_step();
        cyc();
        vecs++;
        if (trace_we[1] !== 1'b0) begin
            errs++;
            $display("FAIL addr0_trace: trace_we1=%b, expected 0", trace_we[1]);
        end
        idle(); re = 2'b11; raddr = '0;
        #1;
        vecs++;
        if (rdata !== 64'h0) begin
            errs++;
            $display("FAIL addr0_read: rdata=%h, expected 0", rdata);
        end
    endtask

    task automatic test_same_cycle_read();
        logic [31:0] exp;
        we0 = 4'hF; waddr0 = 5'd7; wdata0 = 32'h1357_2468;
        model_step();
        cyc();
        we0 = 4'hF; waddr0 = 5'd7; wdata0 = 32'hCAFE_F00D;
        re = 2'b10; raddr = {5'd7, 5'd0};
`ifdef REGFILE_BYPASS_EN
        exp = 32'hCAFE_F00D;
`else
        exp = 32'h1357_2468;
`endif
        #1;
        vecs++;
        if (rdata[63:32] !== exp) begin
            errs++;
            $display("FAIL same_cycle_read: rdata1=%h, expected %h", rdata[63:32], exp);
        end
        model_step();
        cyc();
        idle();
        #1;
        vecs++;
        if (rdata[63:32] !== 32'hCAFE_F00D) begin
            errs++;
            $display("FAIL next_cycle_read: rdata1=%h, expected cafef00d", rdata[63:32]);
        end
    endtask

    task automatic test_random();
        logic [31:0] e0, e1;
        for (int i = 0; i < 300; i++) begin
            we0 = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
            we1 = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
            waddr0 = 5'($urandom % 8);
            waddr1 = ($urandom % 3 == 0) ? waddr0 : 5'($urandom % 8);
            wdata0 = $urandom; wdata1 = $urandom;
            pc0 = $urandom; pc1 = $urandom;
            re = 2'($urandom);
            raddr[4:0] = ($urandom % 2 == 0) ? waddr0 : 5'($urandom % 8);
            raddr[9:5] = ($urandom % 2 == 0) ? waddr1 : 5'($urandom % 8);
            #1;
            e0 = exp_read(0);
            e1 = exp_read(1);
            vecs++;
            if (rdata !== {e1, e0}) begin
                errs++;
                $display("FAIL rand_read[%0d]: rdata=%h, expected %h", i, rdata, {e1, e0});
            end
            model_step();
            cyc();
            vecs++;
            if ({trace_we, trace_addr, trace_data, trace_pc} !==
                {etw, eta[1], eta[0], etd[1], etd[0], etp[1], etp[0]}) begin
                errs++;
                $display("FAIL rand_trace[%0d]: got we=%b a=%h d=%h pc=%h, expected we=%b a=%h d=%h pc=%h",
                         i, trace_we, trace_addr, trace_data, trace_pc,
                         etw, {eta[1], eta[0]}, {etd[1], etd[0]}, {etp[1], etp[0]});
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        int n;
        we0 = 4'hF; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF; pc0 = 32'h400;
        we1 = 4'hF; waddr1 = 5'd31; wdata1 = 32'h0BAD_CAFE; pc1 = 32'h404;
        model_step();
        cyc();
        idle();
        rst = 1'b0;
        cyc();
        model_reset();
        vecs++;
        if ({ready, trace_we} !== 3'b000) begin
            errs++;
            $display("FAIL midreset_edge: ready=%b trace_we=%b, expected 0/00", ready, trace_we);
        end
        rst = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            cyc();
            n++;
        end
        vecs++;
        if (n !== 31) begin
            errs++;
            $display("FAIL midreset_clear_len: ready after %0d cycles, expected 31", n);
        end
        re = 2'b11;
        for (int a = 0; a < 32; a += 2) begin
            raddr = {5'(a + 1), 5'(a)};
            #1;
            vecs++;
            if (rdata !== 64'h0) begin
                errs++;
                $display("FAIL midreset_read[%0d]: rdata=%h, expected 0", a, rdata);
            end
        end
    endtask

    initial begin
        rst = 1'b0; idle(); re = '0; raddr = '0;
        model_reset();
        test_reset();
        test_basic_write();
        test_merge();
        test_addr0();
        test_same_cycle_read();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
